// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage for the slt ALU: registers operands onto R2/R3, waits SETTLE cycles,
// then captures R1/c_out and offers them downstream over a valid/ready handshake.
`timescale 1ns / 1ps

module alu_issue_ctrl #(
    parameter int unsigned size   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_a,
    input  logic [size-1:0] in_b,
    output logic [size-1:0] alu_r2,
    output logic [size-1:0] alu_r3,
    input  logic [size-1:0] alu_r1,
    input  logic            alu_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_result,
    output logic            out_cout,
    output logic            busy,
    output logic [7:0]      res_count
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_settle_range
        $error("SETTLE must be in 1..255");
    end

    localparam logic [7:0] SettleInit = 8'(SETTLE);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q;
    logic       accept;
    logic       capture;
    logic       handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)    state_d = StWait;
            StWait:  if (capture)   state_d = StDone;
            StDone:  if (handshake) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
    always_comb begin
        in_ready  = rst_n & (state_q == StIdle);
        busy      = (state_q != StIdle);
        accept    = in_valid & in_ready;
        capture   = (state_q == StWait) && (cnt_q == 8'd1);
        handshake = out_valid & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            alu_r2     <= '0;
            alu_r3     <= '0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_valid  <= 1'b0;
            res_count  <= 8'd0;
        end else begin
            if (accept) begin
                alu_r2 <= in_a;
                alu_r3 <= in_b;
                cnt_q  <= SettleInit;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 8'd1;
            end

            // ALU outputs are only looked at on the final WAIT edge.
            if (capture) begin
                out_result <= alu_r1;
                out_cout   <= alu_cout;
                out_valid  <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            if (handshake && (res_count != 8'hFF)) begin
                res_count <= res_count + 8'd1;
            end
        end
    end

endmodule
